// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan
// Purpose  : Serial seven-segment scanner for a 74HC595-style shift-register
//            display chain. Multiplexes CHANNELS banks of hex digits onto
//            DIGITS common-select digits; a debounced active-low key steps
//            through the banks.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DIGITS   : digits per bank / width of the one-hot select field (1..16)
//   CHANNELS : number of selectable value banks (1..16)
//   DIV      : clk cycles per tick (half shift-clock period), >= 2
//   DEB      : clk cycles the key must be stable before a change is taken
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   val      : bank c digit i = val[(c*DIGITS+i)*4 +: 4], digit 0 = LS digit
//   dp       : decimal point enable per digit, active-high
//   key      : raw push-key, active-low, asynchronous
//   ds       : serial data to the chain
//   shclk    : shift clock (chain samples ds on its rising edge)
//   stclk    : latch strobe (chain latches on its rising edge)
//   ch       : currently displayed bank
// Build option
//   SEG_SCAN_LZB_EN : when defined, enables leading-zero blanking
// ============================================================================
module seg_scan #(
  parameter  int DIGITS   = 8,
  parameter  int CHANNELS = 4,
  parameter  int DIV      = 4,
  parameter  int DEB      = 20000,
  localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*DIGITS*4-1:0] val,
  input  logic [DIGITS-1:0]            dp,
  input  logic                         key,
  output logic                         ds,
  output logic                         shclk,
  output logic                         stclk,
  output logic [CHW-1:0]               ch
);

  localparam int FB = 8 + DIGITS;                          // bits per frame
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = $clog2(FB);
  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int KW = $clog2(DEB + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Active-low segment pattern for a hex nibble; bit 0 is the decimal point.
  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'h03;  4'h1: s = 8'h9F;  4'h2: s = 8'h25;  4'h3: s = 8'h0D;
      4'h4: s = 8'h99;  4'h5: s = 8'h49;  4'h6: s = 8'h41;  4'h7: s = 8'h1F;
      4'h8: s = 8'h01;  4'h9: s = 8'h09;  4'hA: s = 8'h11;  4'hB: s = 8'hC1;
      4'hC: s = 8'h63;  4'hD: s = 8'h85;  4'hE: s = 8'h61;  default: s = 8'h71;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [TW-1:0]  div_q,     div_d;
  logic           sync1_q,   sync1_d;
  logic           sync2_q,   sync2_d;
  logic           key_lvl_q, key_lvl_d;
  logic [KW-1:0]  deb_q,     deb_d;
  logic [CHW-1:0] ch_q,      ch_d;
  logic [2:0]     state_q,   state_d;
  logic [DW-1:0]  dig_q,     dig_d;
  logic [BW-1:0]  bit_q,     bit_d;
  logic [FB-1:0]  frame_q,   frame_d;
  logic           ds_q,      ds_d;
  logic           shclk_q,   shclk_d;
  logic           stclk_q,   stclk_d;

  logic                  tick;
  logic                  press;
  logic [DIGITS*4-1:0]   bank;
  logic [3:0]            nib;
  logic                  blank;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     sel;
  logic [FB-1:0]         frame_word;
  logic [BW-1:0]         bit_nx;

  // --------------------------------------------------------------------------
  // Tick generator: one-cycle pulse every DIV clocks
  // --------------------------------------------------------------------------
  always_comb begin
    tick  = (int'(div_q) == DIV - 1);
    div_d = tick ? '0 : div_q + TW'(1);
  end

  // --------------------------------------------------------------------------
  // Key synchroniser, debounce and bank stepping. The counter only runs while
  // the synchronised key disagrees with the accepted level, so any bounce
  // shorter than DEB restarts it from zero.
  // --------------------------------------------------------------------------
  always_comb begin
    sync1_d   = key;
    sync2_d   = sync1_q;
    key_lvl_d = key_lvl_q;
    deb_d     = '0;
    press     = 1'b0;
    if (sync2_q != key_lvl_q) begin
      if (int'(deb_q) == DEB - 1) begin
        key_lvl_d = sync2_q;
        press     = ~sync2_q;          // accepted 1->0 transition
      end else begin
        deb_d = deb_q + KW'(1);
      end
    end
    ch_d = ch_q;
    if (press) begin
      ch_d = (int'(ch_q) == CHANNELS - 1) ? '0 : ch_q + CHW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Frame word for the current bank/digit: {sel, seg}, shifted from bit 0
  // --------------------------------------------------------------------------
  always_comb begin
    bank  = val[int'(ch_q)*DIGITS*4 +: DIGITS*4];
    nib   = bank[int'(dig_q)*4 +: 4];
`ifdef SEG_SCAN_LZB_EN
    // Blank when this and every higher digit are zero with no decimal point.
    blank = (dig_q != '0);
    for (int j = 0; j < DIGITS; j++) begin
      if ((j >= int'(dig_q)) && ((bank[j*4 +: 4] != 4'h0) || dp[j])) begin
        blank = 1'b0;
      end
    end
`else
    blank = 1'b0;
`endif
    if (blank) begin
      seg = 8'hFF;
    end else begin
      seg      = hex_seg(nib);
      seg[0]   = seg[0] & ~dp[dig_q];
    end
    for (int j = 0; j < DIGITS; j++) begin
      sel[j] = (j == (DIGITS - 1 - int'(dig_q)));
    end
    frame_word = {sel, seg};
  end

  // --------------------------------------------------------------------------
  // Shift / latch sequencer, one step per tick
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    ds_d    = ds_q;
    shclk_d = shclk_q;
    stclk_d = stclk_q;
    bit_nx  = bit_q + BW'(1);
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          shclk_d = 1'b0;
          state_d = S_LOAD;
        end
        S_LOAD: begin
          // Snapshot: the whole frame is frozen here, so later input changes
          // only take effect at the next LOAD.
          frame_d = frame_word;
          ds_d    = frame_word[0];
          bit_d   = '0;
          shclk_d = 1'b0;
          state_d = S_HIGH;
        end
        S_HIGH: begin
          shclk_d = 1'b1;
          state_d = (int'(bit_q) < FB - 1) ? S_LOW : S_LATCH;
        end
        S_LOW: begin
          shclk_d = 1'b0;
          bit_d   = bit_nx;
          ds_d    = frame_q[bit_nx];
          state_d = S_HIGH;
        end
        S_LATCH: begin
          shclk_d = 1'b0;
          stclk_d = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: begin
          stclk_d = 1'b0;
          dig_d   = (int'(dig_q) == DIGITS - 1) ? '0 : dig_q + DW'(1);
          state_d = S_LOAD;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      key_lvl_q <= 1'b1;
      deb_q     <= '0;
      ch_q      <= '0;
      state_q   <= S_IDLE;
      dig_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      ds_q      <= 1'b0;
      shclk_q   <= 1'b0;
      stclk_q   <= 1'b0;
    end else begin
      div_q     <= div_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      key_lvl_q <= key_lvl_d;
      deb_q     <= deb_d;
      ch_q      <= ch_d;
      state_q   <= state_d;
      dig_q     <= dig_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      ds_q      <= ds_d;
      shclk_q   <= shclk_d;
      stclk_q   <= stclk_d;
    end
  end

  assign ds    = ds_q;
  assign shclk = shclk_q;
  assign stclk = stclk_q;
  assign ch    = ch_q;

endmodule
`default_nettype wire

// File: doc/seg_scan.md
# seg_scan

Parametrised serial seven-segment scanner for a 74HC595-style shift-register display chain. It multiplexes `CHANNELS` banks of hexadecimal digits onto `DIGITS` common-select digits. A debounced push-key steps through the banks. It generates the serial data, shift clock and latch strobe, and sits between the measurement blocks (frequency/duty/pulse-width counters) and the board display pins.

## Interface
- `DIGITS`, 8: digits per bank and width of the one-hot select field; legal range 1..16.
- `CHANNELS`, 4: number of selectable value banks; legal range 1..16.
- `DIV`, 4: `clk` cycles per tick, where a tick is a half shift-clock period; minimum 2.
- `DEB`, 20000: `clk` cycles the key must be stable before a level change is accepted; minimum 2.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous assert, active-low reset.
- `val` input CHANNELS·DIGITS·4: bank c, digit i is nibble `val[(c*DIGITS+i)*4 +: 4]`; digit 0 is the least significant.
- `dp` input DIGITS: decimal point enable per digit, active-high.
- `key` input 1: raw push-key, active-low, asynchronous.
- `ds` output 1: serial data to the chain.
- `shclk` output 1: shift clock; the chain samples `ds` on the rising edge of `shclk`.
- `stclk` output 1: latch strobe; the chain latches on the rising edge of `stclk`.
- `ch` output clog2(CHANNELS) (minimum 1): currently displayed bank.

## Operation
- **Key path**
  - 2-FF synchroniser, then a debounce counter.
  - The stable level updates only after `DEB` consecutive equal samples.
  - A stable 1→0 transition is a press: `ch <= (ch == CHANNELS-1) ? 0 : ch+1`.
- **Segment encoding**
  - Active-low segments; a 0 bit lights the segment.
  - Hex lookup, nibble 0..F: 03,9F,25,0D,99,49,41,1F,01,09,11,C1,63,85,61,71.
  - Bit 0 is the decimal point: if `dp[i]`=1, bit 0 is forced to 0.
  - Blank digit = 0xFF.
- **Frame**
  - One frame per digit, FB = 8+DIGITS bits.
  - Frame bits 0..7 are `seg[0..7]`; bits 8..FB-1 are `sel[0..DIGITS-1]`.
  - `sel` is one-hot active-high with bit DIGITS-1-i set for digit i. For DIGITS=8, digit 0 gives sel=0x80.
  - Bits are shifted in order from bit 0.
- **Snapshot**
  - At the first tick of each frame, the block registers the `ch` bank's nibble for the current digit, `dp`, and the blanking decision.
  - Input changes mid-frame have no effect until the next frame.
- **FSM** (advances one step per tick)
  - IDLE: one tick after reset, `shclk`=0 → LOAD.
  - LOAD: snapshot, `ds` = frame bit 0, `shclk`=0 → HIGH.
  - HIGH: `shclk`=1. If the bit index < FB-1 → LOW; otherwise → LATCH.
  - LOW: `shclk`=0, bit index +1, `ds` = next bit → HIGH.
  - LATCH: `shclk`=0, `stclk`=1 → DONE.
  - DONE: `stclk`=0, digit index wraps DIGITS-1→0 → LOAD.
- **Edge cases**
  - A key press during a frame changes `ch` immediately; the displayed bank follows at the next LOAD.
  - CHANNELS=1: presses are accepted, `ch` stays 0.
  - A `rst_n` assertion mid-frame forces all outputs low immediately and abandons the partial frame. The chain is not latched, because `stclk` is not pulsed.

## Timing
- Reset values:
  - `ds`=0, `shclk`=0, `stclk`=0, `ch`=0.
  - Digit index = 0, bit index = 0, FSM = IDLE.
  - Debounced key level = 1.
- A tick is one pulse every DIV `clk` cycles. Outputs change only on tick edges and are registered.
- Frame length = 2·FB+2 ticks; full scan = DIGITS frames.
- `ds` is stable for 1 tick before and 1 tick after each `shclk` rising edge.
- `stclk` is high for exactly 1 tick, starting 1 tick after the last `shclk` rise.
- Press latency: `ch` updates 2+DEB `clk` cycles after the key level settles.
- First `stclk` rise after reset release: (1+2·FB+1)·DIV cycles, ±1 tick phase.

## Configuration
- `SEG_SCAN_LZB_EN`: leading-zero blanking.
  - Defined: digit i>0 is blanked (0xFF, decimal point also suppressed) when it and all higher digits of the bank are 0 and none of their `dp` bits are set. Digit 0 is never blanked.
  - Undefined: all digits are always displayed.

## Test plan
1. Reset release, DIGITS=8, DIV=2, `val` bank0=0x12345678, `dp`=0 → first frame shifts seg 0x01 then sel 0x80, bit 0 first. `stclk` pulses once after 16 `shclk` rises, and 2·16+2 ticks elapse between `stclk` pulses.
2. Full scan of bank0=0x12345678 → digits 0..7 carry seg bytes 01,1F,41,49,99,0D,25,9F with sel 0x80..0x01.
3. Key held low for DEB+5 cycles, with a 3-cycle bounce glitch before it → `ch`: 0→1 exactly once. Four presses with CHANNELS=4 → `ch` wraps back to 0. Bank 1 appears starting at the next frame.
4. `dp[3]`=1 with digit 3 = 0x5 → seg byte 0x48.
5. With SEG_SCAN_LZB_EN, bank=0x00000A00 → digits 3..7 send 0xFF, digits 0..2 send 0x03,0x03,0x11. Without the macro, digits 3..7 send 0x03.
6. Assert `rst_n` at frame bit 7 → `ds`/`shclk`/`stclk`/`ch` are 0 in the same cycle, no `stclk` pulse occurs, and after release the scan restarts at digit 0, bit 0.
